// File: rtl/service_arbiter_pkg.sv
// Shared constants, state encoding and one-hot helpers for the front-panel arbiter.
// Bit 3 of every service vector is service 1, bit 0 is service 4.
package service_arbiter_pkg;

  localparam int N_SVC = 4;

  localparam logic [N_SVC-1:0] SVC1     = 4'b1000;
  localparam logic [N_SVC-1:0] SVC2     = 4'b0100;
  localparam logic [N_SVC-1:0] SVC3     = 4'b0010;
  localparam logic [N_SVC-1:0] SVC4     = 4'b0001;
  localparam logic [N_SVC-1:0] SVC_NONE = 4'b0000;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACTIVE = 2'd1,
    ST_DONE   = 2'd2
  } state_e;

  typedef logic [1:0] svc_idx_t;

  function automatic logic is_onehot(input logic [N_SVC-1:0] v);
    return (v != SVC_NONE) && ((v & (v - N_SVC'(1))) == SVC_NONE);
  endfunction

  function automatic logic is_multi(input logic [N_SVC-1:0] v);
    return (v & (v - N_SVC'(1))) != SVC_NONE;
  endfunction

  function automatic svc_idx_t onehot_idx(input logic [N_SVC-1:0] v);
    svc_idx_t idx;
    idx = '0;
    for (int i = 0; i < N_SVC; i++) begin
      if (v[i]) idx = svc_idx_t'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/service_arbiter_sync_edge.sv
// Two-flop synchronizer with a third flop for rising-edge detection.
// sync is 2 cycles behind d; rise is high while sync=1 and the third flop is still 0.
module service_arbiter_sync_edge #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         resetn,
  input  logic [W-1:0] d,
  output logic [W-1:0] sync,
  output logic [W-1:0] rise
);

  logic [W-1:0] s1;
  logic [W-1:0] s2;
  logic [W-1:0] s3;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      s1 <= '0;
      s2 <= '0;
      s3 <= '0;
    end else begin
      s1 <= d;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign sync = s2;
  assign rise = s2 & ~s3;

endmodule

// File: rtl/service_arbiter.sv
// Grants buttons and display to one service chosen by the mode switches; shows current_time when idle.
// Switch-to-grant latency 3 cycles; every output is registered.
module service_arbiter
  import service_arbiter_pkg::*;
(
  input  logic              clk,
  input  logic              resetn,
  input  logic [N_SVC-1:0]  spdt_service,
  input  logic [4:0]        push,
  input  logic [N_SVC-1:0]  finish,
  input  logic [16*N_SVC-1:0] svc_num,
  input  logic [15:0]       current_time,
  output logic [N_SVC-1:0]  grant,
  output logic [4:0]        push_pulse,
  output logic [15:0]       disp_num,
  output logic [N_SVC-1:0]  spdt_led,
  output logic              abort,
  output logic              err_multi
);

  logic [N_SVC-1:0] spdt_s2;
  logic [N_SVC-1:0] spdt_rise_unused;
  logic [4:0]       push_s2_unused;
  logic [4:0]       push_rise;

  service_arbiter_sync_edge #(.W(N_SVC)) u_spdt_sync (
    .clk    (clk),
    .resetn (resetn),
    .d      (spdt_service),
    .sync   (spdt_s2),
    .rise   (spdt_rise_unused)
  );

  service_arbiter_sync_edge #(.W(5)) u_push_sync (
    .clk    (clk),
    .resetn (resetn),
    .d      (push),
    .sync   (push_s2_unused),
    .rise   (push_rise)
  );

  logic [15:0] svc_slice [N_SVC];

  for (genvar g = 0; g < N_SVC; g++) begin : g_slice
    assign svc_slice[g] = svc_num[16*g +: 16];
  end

  state_e   state;
  svc_idx_t idx;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state      <= ST_IDLE;
      idx        <= '0;
      grant      <= SVC_NONE;
      spdt_led   <= SVC_NONE;
      disp_num   <= '0;
      push_pulse <= '0;
      abort      <= 1'b0;
      err_multi  <= 1'b0;
    end else begin
      abort      <= 1'b0;
      push_pulse <= '0;
      err_multi  <= 1'b0;
      case (state)
        ST_IDLE: begin
          disp_num <= current_time;
          if (is_onehot(spdt_s2)) begin
            state    <= ST_ACTIVE;
            idx      <= onehot_idx(spdt_s2);
            grant    <= spdt_s2;
            spdt_led <= spdt_s2;
          end else begin
            err_multi <= is_multi(spdt_s2);
          end
        end
        ST_ACTIVE: begin
          disp_num <= svc_slice[idx];
          // Finish has priority over a simultaneous switch drop.
          if (finish[idx]) begin
            state    <= ST_DONE;
            grant    <= SVC_NONE;
            spdt_led <= SVC_NONE;
          end else if (!spdt_s2[idx]) begin
            state    <= ST_IDLE;
            abort    <= 1'b1;
            grant    <= SVC_NONE;
            spdt_led <= SVC_NONE;
          end else begin
            push_pulse <= push_rise;
          end
        end
        ST_DONE: begin
          // Display holds the value captured on the finish cycle.
          if (spdt_s2 == SVC_NONE) state <= ST_IDLE;
        end
        default: begin
          state    <= ST_IDLE;
          grant    <= SVC_NONE;
          spdt_led <= SVC_NONE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_service_arbiter.sv
// Directed bench for service_arbiter: reset, grant flow, push pulses, abort, multi-switch error.
module tb_service_arbiter;

  logic        clk;
  logic        resetn;
  logic [3:0]  spdt_service;
  logic [4:0]  push;
  logic [3:0]  finish;
  logic [63:0] svc_num;
  logic [15:0] current_time;
  logic [3:0]  grant;
  logic [4:0]  push_pulse;
  logic [15:0] disp_num;
  logic [3:0]  spdt_led;
  logic        abort;
  logic        err_multi;

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;
  int cnt;

  service_arbiter dut (
    .clk          (clk),
    .resetn       (resetn),
    .spdt_service (spdt_service),
    .push         (push),
    .finish       (finish),
    .svc_num      (svc_num),
    .current_time (current_time),
    .grant        (grant),
    .push_pulse   (push_pulse),
    .disp_num     (disp_num),
    .spdt_led     (spdt_led),
    .abort        (abort),
    .err_multi    (err_multi)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    resetn       = 1'b0;
    spdt_service = 4'b0000;
    push         = 5'b00000;
    finish       = 4'b0000;
    svc_num      = {16'h0905, 16'h0222, 16'h0333, 16'h0444};
    current_time = 16'h1234;
    #1;
    check("rst_grant", 32'(grant), 32'h0);
    check("rst_disp", 32'(disp_num), 32'h0);
    check("rst_led", 32'(spdt_led), 32'h0);
    tick(2);
    resetn = 1'b1;
    tick();
    check("idle_disp", 32'(disp_num), 32'h1234);
    check("idle_grant", 32'(grant), 32'h0);
    check("idle_led", 32'(spdt_led), 32'h0);

    // Service 1: grant after 3 edges, display one cycle later, finish captures.
    spdt_service = 4'b1000;
    tick(2);
    check("s1_grant_e2", 32'(grant), 32'h0);
    tick();
    check("s1_grant_e3", 32'(grant), 32'h8);
    check("s1_led_e3", 32'(spdt_led), 32'h8);
    check("s1_disp_e3", 32'(disp_num), 32'h1234);
    tick();
    check("s1_disp_e4", 32'(disp_num), 32'h0905);
    svc_num[63:48] = 16'h0930;
    finish = 4'b1000;
    tick();
    check("s1_done_grant", 32'(grant), 32'h0);
    check("s1_done_disp", 32'(disp_num), 32'h0930);
    finish = 4'b0000;
    svc_num[63:48] = 16'h0999;
    tick();
    check("s1_done_hold", 32'(disp_num), 32'h0930);
    spdt_service = 4'b0000;
    tick(4);
    check("s1_idle_disp", 32'(disp_num), 32'h1234);
    check("s1_idle_abort", 32'(abort), 32'h0);

    // Service 2: held button gives exactly one pulse.
    spdt_service = 4'b0100;
    tick(3);
    check("s2_grant", 32'(grant), 32'h4);
    push = 5'b00001;
    cnt = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (push_pulse[0]) cnt++;
    end
    check("s2_push_count", 32'(cnt), 32'd1);
    push = 5'b00000;
    spdt_service = 4'b0000;
    tick(5);
    push = 5'b00001;
    cnt = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (push_pulse != 5'b00000) cnt++;
    end
    check("idle_push_count", 32'(cnt), 32'd0);
    push = 5'b00000;
    tick(3);

    // Service 3: switch drop aborts for one cycle.
    spdt_service = 4'b0010;
    tick(3);
    check("s3_grant", 32'(grant), 32'h2);
    spdt_service = 4'b0000;
    tick(2);
    check("s3_abort_pre", 32'(abort), 32'h0);
    tick();
    check("s3_abort", 32'(abort), 32'h1);
    check("s3_abort_grant", 32'(grant), 32'h0);
    tick();
    check("s3_abort_clr", 32'(abort), 32'h0);

    // Finish together with switch drop: no abort, one DONE cycle, then idle.
    spdt_service = 4'b0010;
    tick(4);
    check("s3b_disp", 32'(disp_num), 32'h0333);
    spdt_service = 4'b0000;
    tick(2);
    finish = 4'b0010;
    tick();
    check("s3b_done_abort", 32'(abort), 32'h0);
    check("s3b_done_grant", 32'(grant), 32'h0);
    finish = 4'b0000;
    tick();
    check("s3b_abort_after", 32'(abort), 32'h0);
    check("s3b_disp_hold", 32'(disp_num), 32'h0333);
    tick();
    check("s3b_idle_disp", 32'(disp_num), 32'h1234);

    // Multiple switches in idle raise the error; then a single one is granted.
    spdt_service = 4'b1100;
    tick(3);
    check("multi_err", 32'(err_multi), 32'h1);
    check("multi_grant", 32'(grant), 32'h0);
    spdt_service = 4'b0100;
    tick(3);
    check("multi_err_clr", 32'(err_multi), 32'h0);
    check("multi_grant_s2", 32'(grant), 32'h4);
    spdt_service = 4'b0110;
    tick(4);
    check("second_sw_grant", 32'(grant), 32'h4);
    check("second_sw_err", 32'(err_multi), 32'h0);
    finish = 4'b1000;
    tick(2);
    check("foreign_finish", 32'(grant), 32'h4);
    finish = 4'b0000;
    check("active_disp", 32'(disp_num), 32'h0222);

    // Asynchronous reset between edges.
    #2;
    resetn = 1'b0;
    #1;
    check("arst_grant", 32'(grant), 32'h0);
    check("arst_led", 32'(spdt_led), 32'h0);
    check("arst_disp", 32'(disp_num), 32'h0);
    check("arst_push", 32'(push_pulse), 32'h0);
    tick(2);
    resetn = 1'b1;
    spdt_service = 4'b0000;
    tick(2);
    check("post_rst_disp", 32'(disp_num), 32'h1234);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
